// File: rtl/keypad_pkg.sv
// Shared types for the matrix keypad scanner: scan FSM states and the
// press/release kind carried by each queued key event.
package keypad_pkg;

  // Scan FSM: hold one column low to let the lines settle, then walk the rows.
  typedef enum logic {
    SETTLE = 1'b0,
    EVAL   = 1'b1
  } scan_state_e;

  // Kind of a debounced transition as stored in the event FIFO.
  typedef enum logic {
    KEV_RELEASE = 1'b0,
    KEV_PRESS   = 1'b1
  } kev_kind_e;

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO for the keypad scanner.
// The head word is visible on pop_data whenever empty is low. A push into a
// full FIFO is accepted only if a pop happens in the same cycle; otherwise it
// is discarded and drop pulses for one cycle.
module key_event_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && full && !do_pop;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples the pre-edge values regardless of statement order.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Event storage.
  // NOTE: the storage array has no reset; occupancy is tracked by count, so
  // stale words are never presented and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with per-key debouncing and a key event FIFO.
// One column is driven low at a time; after SETTLE_CYC cycles each row of
// that column is evaluated on its own cycle. A key's debounced state flips
// after DB_FRAMES consecutive frames that disagree with it.
// Build option: define KEYPAD_RELEASE_EVENT_EN to queue release events as
// well as press events; otherwise only presses are queued and ev_press is 1.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE_CYC = 16,
  parameter int DB_FRAMES  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      col,
  output logic [ROWS*COLS-1:0] keys,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] ev_code,
  output logic                 ev_press,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int NKEYS  = ROWS * COLS;
  localparam int CODE_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int CNT_W  = $clog2(DB_FRAMES + 1);
  localparam int SET_W  = $clog2(SETTLE_CYC);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam int EV_W   = CODE_W + 1;
`else
  localparam int EV_W   = CODE_W;
`endif

  logic [ROWS-1:0]   row_meta;
  logic [ROWS-1:0]   row_sync;
  scan_state_e       state_q, state_d;
  logic              run_q;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [ROW_W-1:0]  row_idx_q, row_idx_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [COLS-1:0]   col_d;
  logic [CNT_W-1:0]  db_cnt_q [NKEYS];
  logic [NKEYS-1:0]  keys_q;
  logic [CODE_W-1:0] key_idx;
  logic              raw;
  logic [CNT_W-1:0]  cnt_inc;
  logic              differ;
  logic              flip;
  logic              ev_push;
  logic [EV_W-1:0]   push_data;
  logic [EV_W-1:0]   pop_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;

  // Two-flop synchronizer on the raw row lines (idle level is high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Scan FSM next state; the column drive is derived from the next column
  // index so col only moves on the edge that enters SETTLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    settle_d  = settle_q;
    if (run_q) begin
      unique case (state_q)
        SETTLE: begin
          if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
            settle_d = '0;
            state_d  = EVAL;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        EVAL: begin
          if (row_idx_q == ROW_W'(ROWS - 1)) begin
            row_idx_d = '0;
            state_d   = SETTLE;
            col_idx_d = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
          end else begin
            row_idx_d = row_idx_q + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
    col_d            = '1;
    col_d[col_idx_d] = 1'b0;
  end

  // Scan FSM registers. run_q spends the first post-reset edge driving
  // column 0 so the first column settles for the full SETTLE_CYC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SETTLE;
      run_q     <= 1'b0;
      col_idx_q <= '0;
      row_idx_q <= '0;
      settle_q  <= '0;
      col       <= '1;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      settle_q  <= settle_d;
      col       <= col_d;
    end
  end

  // Debounce decision for the key addressed by the current EVAL cycle.
  always_comb begin
    key_idx = CODE_W'(row_idx_q) * CODE_W'(COLS) + CODE_W'(col_idx_q);
    raw     = ~row_sync[row_idx_q];
    cnt_inc = db_cnt_q[key_idx] + CNT_W'(1);
    differ  = (state_q == EVAL) && (raw != keys_q[key_idx]);
    flip    = differ && (cnt_inc == CNT_W'(DB_FRAMES));
`ifdef KEYPAD_RELEASE_EVENT_EN
    ev_push = flip;
`else
    ev_push = flip && raw;
`endif
  end

  // Per-key debounce counters and debounced key bitmap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys_q <= '0;
      for (int i = 0; i < NKEYS; i++) db_cnt_q[i] <= '0;
    end else if (state_q == EVAL) begin
      if (!differ) begin
        db_cnt_q[key_idx] <= '0;
      end else if (flip) begin
        db_cnt_q[key_idx] <= '0;
        keys_q[key_idx]   <= raw;
      end else begin
        db_cnt_q[key_idx] <= cnt_inc;
      end
    end
  end

  assign keys = keys_q;

`ifdef KEYPAD_RELEASE_EVENT_EN
  kev_kind_e push_kind;
  assign push_kind = raw ? KEV_PRESS : KEV_RELEASE;
  assign push_data = {key_idx, push_kind};
  assign ev_code   = pop_data[EV_W-1:1];
  assign ev_press  = pop_data[0];
`else
  assign push_data = key_idx;
  assign ev_code   = pop_data;
  assign ev_press  = KEV_PRESS;
`endif

  key_event_fifo #(
    .DATA_W (EV_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ev_push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (ev_ready),
    .pop_data  (pop_data),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign ev_valid = !fifo_empty;

  // Sticky overflow flag; a clear in the same cycle as a drop wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            ovf <= 1'b0;
    else if (ovf_clr)    ovf <= 1'b0;
    else if (fifo_drop)  ovf <= 1'b1;
  end

  // A dropped event can only come from a full FIFO.
  drop_needs_full: assert property (@(posedge clk) disable iff (!rst) fifo_drop |-> fifo_full);

endmodule
